// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, unsigned or signed, magnitude plus sign outputs.
// Uses the enter/done handshake; results are registered and held until the next completion.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enter,
  input  logic             sgd,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             sign,
  output logic             remSign,
  output logic             valid
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, SHIFT = 3'd2, FIX = 3'd3, DONE = 3'd4;
  localparam int CW = $clog2(WIDTH + 1);
  logic [2:0]       state;
  logic [WIDTH-1:0] a_r, b_r, quot, rem, mag_a, mag_b;
  logic [WIDTH:0]   rem_sh;
  logic [CW-1:0]    cnt;
  logic             s_r, start, last, ge, div_ok, q_neg, r_neg;
  // DONE also accepts enter so a held request restarts one cycle after done
  assign start  = enter && (state == IDLE || state == DONE);
  assign busy   = state != IDLE;
  assign done   = state == DONE;
  assign mag_a  = (s_r && a_r[WIDTH-1]) ? -a_r : a_r;
  assign mag_b  = (s_r && b_r[WIDTH-1]) ? -b_r : b_r;
  assign q_neg  = s_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
  assign r_neg  = s_r & a_r[WIDTH-1];
  assign rem_sh = {rem, quot[WIDTH-1]};
  assign ge     = rem_sh >= {1'b0, mag_b};
  assign div_ok = |mag_b;
  // the extra SHIFT cycle after the last iteration keeps the fixed WIDTH+3 latency
  assign last   = cnt == CW'(WIDTH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= 1'b0;
      quot    <= '0;
      rem     <= '0;
      cnt     <= '0;
      Q       <= '0;
      R       <= '0;
      sign    <= 1'b0;
      remSign <= 1'b0;
      valid   <= 1'b0;
    end else begin
      if (start) begin
        a_r <= A;
        b_r <= B;
        s_r <= sgd;
      end
      case (state)
        IDLE: state <= start ? LOAD : IDLE;
        LOAD: begin
          quot  <= mag_a;
          rem   <= '0;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (!last) begin
            rem  <= ge ? WIDTH'(rem_sh - {1'b0, mag_b}) : rem_sh[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], ge};
          end
          cnt   <= cnt + 1'b1;
          state <= last ? FIX : SHIFT;
        end
        FIX: begin
          valid   <= div_ok;
          Q       <= div_ok ? quot : '1;
          R       <= div_ok ? rem : mag_a;
          sign    <= div_ok & q_neg & (|quot);
          remSign <= r_neg & (div_ok ? |rem : 1'b1);
          state   <= DONE;
        end
        DONE:    state <= start ? LOAD : IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
